uart_cmd_decoder: RTL and testbench
===================================

// Module: uart_cmd_decoder
// PURPOSE
//   Receive-side command parser for the serial-out controller. Consumes bytes from the UART
//   receiver (rx_done_tick/rx_data), assembles DATA (0x0B) and FREQ (0x0A) frames, and
//   presents registered pattern, channel, mode and period fields with one-cycle valid
//   strobes. It is the decoder for the host command stream and feeds diff_freq_serial_out.
// PARAMETERS
//   PACK_NUM            4       pattern bytes per frame
//   DATA_BIT            32      pattern width, = 8*PACK_NUM
//   DEFAULT_SLOW_PERIOD 8'd20   slow_period_o reset value
//   DEFAULT_FAST_PERIOD 8'd5    fast_period_o reset value
//   TIMEOUT_CYCLES      100000  inter-byte timeout in clk_i cycles (>=2)
// PORTS
//   clk_i              in   1         system clock
//   rst_ni             in   1         async active-low reset
//   rx_done_tick_i     in   1         one-cycle strobe, rx_data_i valid
//   rx_data_i          in   8         received byte
//   data_o             out  DATA_BIT  pattern from last good DATA frame
//   channel_o          out  4         ctrl[7:4] of last DATA frame
//   mode_o             out  1         ctrl[2]: 0 one-shot, 1 repeat
//   op_o               out  2         ctrl[1:0]
//   data_valid_tick_o  out  1         pulse: DATA frame complete
//   slow_period_o      out  8         slow bit period, last FREQ frame
//   fast_period_o      out  8         fast bit period, last FREQ frame
//   freq_valid_tick_o  out  1         pulse: FREQ frame complete
//   err_tick_o         out  1         pulse: unknown command or timeout
//   ack_start_o        out  1         pulse: request UART TX of ack_data_o
//   ack_data_o         out  8         ack byte
// BEHAVIOUR
//   - Reset: all outputs 0 except slow/fast_period_o = DEFAULT_*; state IDLE, counters 0.
//   - States: IDLE, DATA_PL, FREQ_PL. Only edges with rx_done_tick_i=1 consume bytes.
//   - IDLE: 0x0B->DATA_PL, 0x0A->FREQ_PL, byte counter=0; other byte -> err_tick_o, stay IDLE.
//   - DATA_PL: PACK_NUM pattern bytes then 1 ctrl byte (PACK_NUM+1 total). Pattern byte k
//     -> shadow[8k+7:8k] (first byte = LSB). Ctrl byte = {channel[3:0], rsvd, mode, op[1:0]};
//     rsvd ignored.
//   - FREQ_PL: PACK_NUM reserved bytes (discarded), then slow period, then fast period.
//   - On the edge consuming the final byte: outputs load from shadow, matching valid tick
//     high for exactly the next cycle, state -> IDLE. Latency 1 clk from final rx tick.
//   - Outputs change only on frame completion; partial/aborted frames never alter them.
//   - Timeout: in DATA_PL/FREQ_PL, counter clears on each rx tick and increments otherwise;
//     at TIMEOUT_CYCLES-1 idle cycles -> err_tick_o one cycle, partial frame dropped, IDLE.
//     Counter held 0 in IDLE.
//   - rx tick in the same cycle as timeout expiry: byte wins; no error, counter clears.
//   - Back-to-back: command byte may arrive the cycle after final byte (valid tick high);
//     it is accepted.
//   - Period value 0 passed through unchecked; clamping is downstream's job.
//   - Reset mid-frame: immediate abort, all reset values, no ticks.
// CONFIGURATION
//   CMD_ACK_EN defined: one cycle after each valid or err tick, ack_start_o pulses once;
//     ack_data_o = cmd|8'h80 (8'h8B/8'h8A) on success, 8'hEE on error; held until next ack.
//   CMD_ACK_EN undefined: ack_start_o and ack_data_o constant 0, no ack logic.
// TESTING
//   1 DATA 0B,55,55,55,55,71 -> data_o=32'h55555555, channel_o=7, mode_o=0, op_o=1,
//     data_valid_tick_o single 1-cycle pulse one clk after 6th rx tick.
//   2 FREQ 0A,11,22,33,44,14,05 -> slow_period_o=8'h14, fast_period_o=8'h05,
//     freq_valid_tick_o 1 cycle; data_o unchanged.
//   3 Byte 3C in IDLE -> err_tick_o 1 cycle; then 0B,01,02,03,04,F5 -> data_o=32'h04030201,
//     channel_o=F, mode_o=1, op_o=1.
//   4 0B,55 then silence > TIMEOUT_CYCLES (bench TIMEOUT_CYCLES=50) -> err_tick_o at idle
//     cycle 49, outputs unchanged; next full frame decodes normally.
//   5 rst_ni low after 0A,11,22 -> periods 20/5, no ticks; full FREQ frame then works.
//   6 CMD_ACK_EN: test 1 -> ack_start_o 1 cycle after data_valid_tick_o, ack_data_o=8'h8B;
//     test 3 bad byte -> ack_data_o=8'hEE. Without macro: ack outputs stay 0 throughout.

Source files
------------

// File: rtl/uart_cmd_decoder_if.sv
// Byte stream from the UART receiver into the command decoder.
// Master drives the strobe and byte, slave consumes them.
interface uart_cmd_decoder_if;
  logic       rx_done_tick_i;
  logic [7:0] rx_data_i;

  modport master (
    output rx_done_tick_i,
    output rx_data_i
  );

  modport slave (
    input rx_done_tick_i,
    input rx_data_i
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Host command parser: DATA (0x0B) and FREQ (0x0A) frames to registered fields.
// Define CMD_ACK_EN to emit an ack byte request after every valid or error tick.
module uart_cmd_decoder #(
  parameter int         PACK_NUM            = 4,
  parameter int         DATA_BIT            = 32,
  parameter logic [7:0] DEFAULT_SLOW_PERIOD = 8'd20,
  parameter logic [7:0] DEFAULT_FAST_PERIOD = 8'd5,
  parameter int         TIMEOUT_CYCLES      = 100000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  uart_cmd_decoder_if.slave   rx,
  output logic [DATA_BIT-1:0] data_o,
  output logic [3:0]          channel_o,
  output logic                mode_o,
  output logic [1:0]          op_o,
  output logic                data_valid_tick_o,
  output logic [7:0]          slow_period_o,
  output logic [7:0]          fast_period_o,
  output logic                freq_valid_tick_o,
  output logic                err_tick_o,
  output logic                ack_start_o,
  output logic [7:0]          ack_data_o
);

  localparam int BW = $clog2(PACK_NUM + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [7:0] CMD_DATA = 8'h0B;
  localparam logic [7:0] CMD_FREQ = 8'h0A;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE,
    DATA_PL,
    FREQ_PL
  } state_t;

  state_t state_q, state_d;

  logic          tick;
  logic [7:0]    byte_d;
  logic [BW-1:0] cnt_q;
  logic [TW-1:0] to_q;
  logic [DATA_BIT-1:0] shadow_q;
  logic [7:0]    slow_q;

  logic last_data;
  logic last_freq;
  logic bad_cmd;
  logic expire;
  logic pat_we;
  logic slow_we;

  assign tick   = rx.rx_done_tick_i;
  assign byte_d = rx.rx_data_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (tick && byte_d == CMD_DATA) state_d = DATA_PL;
        else if (tick && byte_d == CMD_FREQ) state_d = FREQ_PL;
      end
      DATA_PL: if (last_data || expire) state_d = IDLE;
      FREQ_PL: if (last_freq || expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decode strobes; a byte in the expiry cycle suppresses the timeout.
  always_comb begin
    last_data = 1'b0;
    last_freq = 1'b0;
    bad_cmd   = 1'b0;
    expire    = 1'b0;
    pat_we    = 1'b0;
    slow_we   = 1'b0;
    unique case (1'b1)
      state_q == IDLE: begin
        bad_cmd = tick && byte_d != CMD_DATA && byte_d != CMD_FREQ;
      end
      state_q == DATA_PL: begin
        last_data = tick && cnt_q == BW'(PACK_NUM);
        pat_we    = tick && cnt_q < BW'(PACK_NUM);
        expire    = !tick && to_q == TO_LAST;
      end
      state_q == FREQ_PL: begin
        last_freq = tick && cnt_q == BW'(PACK_NUM + 1);
        slow_we   = tick && cnt_q == BW'(PACK_NUM);
        expire    = !tick && to_q == TO_LAST;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      to_q  <= '0;
    end else if (state_q == IDLE || state_d == IDLE) begin
      cnt_q <= '0;
      to_q  <= '0;
    end else if (tick) begin
      cnt_q <= cnt_q + BW'(1);
      to_q  <= '0;
    end else begin
      to_q  <= to_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      slow_q   <= '0;
    end else begin
      for (int k = 0; k < PACK_NUM; k++) begin
        if (pat_we && cnt_q == BW'(k)) shadow_q[8*k +: 8] <= byte_d;
      end
      if (slow_we) slow_q <= byte_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o            <= '0;
      channel_o         <= '0;
      mode_o            <= 1'b0;
      op_o              <= '0;
      slow_period_o     <= DEFAULT_SLOW_PERIOD;
      fast_period_o     <= DEFAULT_FAST_PERIOD;
      data_valid_tick_o <= 1'b0;
      freq_valid_tick_o <= 1'b0;
      err_tick_o        <= 1'b0;
    end else begin
      data_valid_tick_o <= last_data;
      freq_valid_tick_o <= last_freq;
      err_tick_o        <= bad_cmd || expire;
      if (last_data) begin
        data_o    <= shadow_q;
        channel_o <= byte_d[7:4];
        mode_o    <= byte_d[2];
        op_o      <= byte_d[1:0];
      end
      if (last_freq) begin
        slow_period_o <= slow_q;
        fast_period_o <= byte_d;
      end
    end
  end

`ifdef CMD_ACK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_start_o <= 1'b0;
      ack_data_o  <= '0;
    end else begin
      ack_start_o <= data_valid_tick_o || freq_valid_tick_o || err_tick_o;
      if (err_tick_o)             ack_data_o <= 8'hEE;
      else if (data_valid_tick_o) ack_data_o <= CMD_DATA | 8'h80;
      else if (freq_valid_tick_o) ack_data_o <= CMD_FREQ | 8'h80;
    end
  end
`else
  assign ack_start_o = 1'b0;
  assign ack_data_o  = '0;
`endif

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder (inter-byte timeout shortened to 50).
// Builds with or without CMD_ACK_EN.
module tb_uart_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data;
  logic [3:0]  channel;
  logic        mode;
  logic [1:0]  op;
  logic        dvt;
  logic [7:0]  slow;
  logic [7:0]  fast;
  logic        fvt;
  logic        err;
  logic        ack_start;
  logic [7:0]  ack_data;

  int n_cmp = 0;
  int n_err = 0;

  uart_cmd_decoder_if rx ();

  uart_cmd_decoder #(
    .PACK_NUM       (4),
    .DATA_BIT       (32),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .rx                (rx.slave),
    .data_o            (data),
    .channel_o         (channel),
    .mode_o            (mode),
    .op_o              (op),
    .data_valid_tick_o (dvt),
    .slow_period_o     (slow),
    .fast_period_o     (fast),
    .freq_valid_tick_o (fvt),
    .err_tick_o        (err),
    .ack_start_o       (ack_start),
    .ack_data_o        (ack_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Byte is consumed at the next edge; returns 1 time unit after it.
  task automatic send_byte(input logic [7:0] b);
    rx.rx_done_tick_i = 1'b1;
    rx.rx_data_i      = b;
    @(posedge clk);
    #1;
    rx.rx_done_tick_i = 1'b0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  int hit;

  initial begin
    rx.rx_done_tick_i = 1'b0;
    rx.rx_data_i      = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", data, 32'h0);
    check("rst_chan", {28'h0, channel}, 32'h0);
    check("rst_mode", {31'h0, mode}, 32'h0);
    check("rst_op", {30'h0, op}, 32'h0);
    check("rst_slow", {24'h0, slow}, 32'd20);
    check("rst_fast", {24'h0, fast}, 32'd5);
    check("rst_ticks", {29'h0, dvt, fvt, err}, 32'h0);
    check("rst_ack", {23'h0, ack_start, ack_data}, 32'h0);
    rst_n = 1'b1;
    step();

    // DATA frame, ctrl 0x71: channel 7, mode 0, op 1
    send_byte(8'h0B);
    repeat (4) send_byte(8'h55);
    check("t1_dvt_early", {31'h0, dvt}, 32'h0);
    send_byte(8'h71);
    check("t1_dvt", {31'h0, dvt}, 32'h1);
    check("t1_data", data, 32'h55555555);
    check("t1_chan", {28'h0, channel}, 32'h7);
    check("t1_mode", {31'h0, mode}, 32'h0);
    check("t1_op", {30'h0, op}, 32'h1);
    check("t1_fvt", {31'h0, fvt}, 32'h0);
    step();
    check("t1_dvt_once", {31'h0, dvt}, 32'h0);
`ifdef CMD_ACK_EN
    check("t1_ack_start", {31'h0, ack_start}, 32'h1);
    check("t1_ack_data", {24'h0, ack_data}, 32'h8B);
`else
    check("t1_ack_off", {23'h0, ack_start, ack_data}, 32'h0);
`endif
    step();
    check("t1_ack_once", {31'h0, ack_start}, 32'h0);

    // FREQ frame
    send_byte(8'h0A);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h14);
    check("t2_fvt_early", {31'h0, fvt}, 32'h0);
    send_byte(8'h05);
    check("t2_fvt", {31'h0, fvt}, 32'h1);
    check("t2_slow", {24'h0, slow}, 32'h14);
    check("t2_fast", {24'h0, fast}, 32'h05);
    check("t2_data_kept", data, 32'h55555555);
    check("t2_dvt", {31'h0, dvt}, 32'h0);
    step();
    check("t2_fvt_once", {31'h0, fvt}, 32'h0);
    step();

    // Unknown command, then DATA frame with ctrl 0xF5
    send_byte(8'h3C);
    check("t3_err", {31'h0, err}, 32'h1);
    check("t3_data_kept", data, 32'h55555555);
    step();
    check("t3_err_once", {31'h0, err}, 32'h0);
`ifdef CMD_ACK_EN
    check("t3_ack_start", {31'h0, ack_start}, 32'h1);
    check("t3_ack_data", {24'h0, ack_data}, 32'hEE);
`else
    check("t3_ack_off", {23'h0, ack_start, ack_data}, 32'h0);
`endif
    send_byte(8'h0B);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'hF5);
    check("t3_dvt", {31'h0, dvt}, 32'h1);
    check("t3_data", data, 32'h04030201);
    check("t3_chan", {28'h0, channel}, 32'hF);
    check("t3_mode", {31'h0, mode}, 32'h1);
    check("t3_op", {30'h0, op}, 32'h1);

    // Command byte the cycle after the final byte
    send_byte(8'h0A);
    check("b2b_dvt_low", {31'h0, dvt}, 32'h0);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h09);
    send_byte(8'h0C);
    check("b2b_fvt", {31'h0, fvt}, 32'h1);
    check("b2b_slow", {24'h0, slow}, 32'h09);
    check("b2b_fast", {24'h0, fast}, 32'h0C);
    step();

    // Timeout after a partial DATA frame: err on idle cycle 49
    send_byte(8'h0B);
    send_byte(8'h55);
    hit = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (err && hit == 0) hit = i;
    end
    check("t4_err_cycle", hit, 49);
    check("t4_data_kept", data, 32'h04030201);
    check("t4_chan_kept", {28'h0, channel}, 32'hF);
    send_byte(8'h0B);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    send_byte(8'h26);
    check("t4_dvt", {31'h0, dvt}, 32'h1);
    check("t4_data", data, 32'hDDCCBBAA);
    check("t4_ctrl", {25'h0, channel, mode, op}, {25'h0, 4'h2, 1'b1, 2'h2});
    step();

    // Byte arriving in the expiry cycle wins
    send_byte(8'h0B);
    repeat (48) @(posedge clk);
    #1;
    send_byte(8'h10);
    check("t4b_no_err", {31'h0, err}, 32'h0);
    send_byte(8'h20);
    send_byte(8'h30);
    send_byte(8'h40);
    send_byte(8'h83);
    check("t4b_dvt", {31'h0, dvt}, 32'h1);
    check("t4b_data", data, 32'h40302010);
    check("t4b_ctrl", {25'h0, channel, mode, op}, {25'h0, 4'h8, 1'b0, 2'h3});
    step();

    // Reset mid-frame
    send_byte(8'h0A);
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    #2;
    check("t5_slow", {24'h0, slow}, 32'd20);
    check("t5_fast", {24'h0, fast}, 32'd5);
    check("t5_data", data, 32'h0);
    check("t5_ticks", {29'h0, dvt, fvt, err}, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    check("t5_quiet", {29'h0, dvt, fvt, err}, 32'h0);
    send_byte(8'h0A);
    repeat (4) send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h07);
    check("t5_fvt", {31'h0, fvt}, 32'h1);
    check("t5_slow0", {24'h0, slow}, 32'h00);
    check("t5_fast7", {24'h0, fast}, 32'h07);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
